// File: rtl/game_ctrl.sv
// Tic-tac-toe turn sequencer: mode flags, 3x3 board, per-square colours,
// move validation and win/draw detection held until restart.
module game_ctrl #(
  parameter logic [11:0] COLOR_X = 12'hF00,
  parameter logic [11:0] COLOR_O = 12'h00F
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         start_req,
  input  logic         choice_valid,
  input  logic         choice_sym,
  input  logic         sel_valid,
  input  logic [3:0]   sel_idx,
  input  logic         restart,
  output logic         start_en,
  output logic         choice_en,
  output logic [8:0]   square_en,
  output logic [8:0]   owner,
  output logic [107:0] square_color,
  output logic         turn,
  output logic         sel_err,
  output logic         game_over,
  output logic [1:0]   winner,
  output logic [7:0]   win_line
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHOICE,
    S_PLAY,
    S_CHECK,
    S_OVER
  } state_t;

  // Square masks: rows 0-2, cols 3-5, diag 0-4-8, diag 2-4-6
  localparam logic [8:0] LINE_M [8] = '{
    9'b000000111, 9'b000111000, 9'b111000000,
    9'b001001001, 9'b010010010, 9'b100100100,
    9'b100010001, 9'b001010100
  };

  state_t         r_state;
  logic           r_start_en;
  logic           r_choice_en;
  logic [8:0]     r_sq;
  logic [8:0]     r_own;
  logic [107:0]   r_color;
  logic           r_turn;
  logic           r_sel_err;
  logic           r_over;
  logic [1:0]     r_winner;
  logic [7:0]     r_line;
  logic [3:0]     r_cnt;

  logic [8:0]     w_sel_oh;
  logic           w_sel_ok;
  logic [7:0]     w_lines;
  logic [11:0]    w_mover_col;

  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < 9; i++)
      w_sel_oh[i] = (sel_idx == 4'(i));
    w_sel_ok = (|w_sel_oh) && !(|(w_sel_oh & r_sq));
    w_lines = '0;
    for (int l = 0; l < 8; l++)
      w_lines[l] = ((r_sq & LINE_M[l]) == LINE_M[l]) &&
                   (((r_own & LINE_M[l]) == LINE_M[l]) ||
                    ((r_own & LINE_M[l]) == 9'd0));
    w_mover_col = r_turn ? COLOR_O : COLOR_X;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_start_en  <= 1'b0;
      r_choice_en <= 1'b0;
      r_sq        <= '0;
      r_own       <= '0;
      r_color     <= '0;
      r_turn      <= 1'b0;
      r_sel_err   <= 1'b0;
      r_over      <= 1'b0;
      r_winner    <= '0;
      r_line      <= '0;
      r_cnt       <= '0;
    end else if (restart) begin
      r_state     <= S_IDLE;
      r_start_en  <= 1'b0;
      r_choice_en <= 1'b0;
      r_sq        <= '0;
      r_own       <= '0;
      r_color     <= '0;
      r_turn      <= 1'b0;
      r_sel_err   <= 1'b0;
      r_over      <= 1'b0;
      r_winner    <= '0;
      r_line      <= '0;
      r_cnt       <= '0;
    end else begin
      r_sel_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_req) begin
            r_state     <= S_CHOICE;
            r_start_en  <= 1'b1;
            r_choice_en <= 1'b1;
          end
        end
        S_CHOICE: begin
          if (choice_valid) begin
            r_state     <= S_PLAY;
            r_choice_en <= 1'b0;
            r_turn      <= choice_sym;
          end
        end
        S_PLAY: begin
          if (sel_valid) begin
            if (w_sel_ok) begin
              r_state <= S_CHECK;
              r_sq    <= r_sq | w_sel_oh;
              r_own   <= r_turn ? (r_own | w_sel_oh)
                                : (r_own & ~w_sel_oh);
              r_cnt   <= r_cnt + 4'd1;
              for (int i = 0; i < 9; i++)
                if (w_sel_oh[i])
                  r_color[12*i +: 12] <= w_mover_col;
            end else begin
              r_sel_err <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (|w_lines) begin
            r_state  <= S_OVER;
            r_over   <= 1'b1;
            r_winner <= r_turn ? 2'b10 : 2'b01;
            r_line   <= w_lines;
          end else if (r_cnt == 4'd9) begin
            r_state  <= S_OVER;
            r_over   <= 1'b1;
            r_winner <= 2'b11;
            r_line   <= '0;
          end else begin
            r_state <= S_PLAY;
            r_turn  <= ~r_turn;
          end
        end
        S_OVER: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_en     = r_start_en;
  assign choice_en    = r_choice_en;
  assign square_en    = r_sq;
  assign owner        = r_own;
  assign square_color = r_color;
  assign turn         = r_turn;
  assign sel_err      = r_sel_err;
  assign game_over    = r_over;
  assign winner       = r_winner;
  assign win_line     = r_line;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized and directed bench for game_ctrl against a board-level
// reference model of the game rules.
module tb_game_ctrl;

  localparam logic [11:0] CX = 12'hF00;
  localparam logic [11:0] CO = 12'h00F;

  logic         pclk;
  logic         rst;
  logic         start_req;
  logic         choice_valid;
  logic         choice_sym;
  logic         sel_valid;
  logic [3:0]   sel_idx;
  logic         restart;
  logic         start_en;
  logic         choice_en;
  logic [8:0]   square_en;
  logic [8:0]   owner;
  logic [107:0] square_color;
  logic         turn;
  logic         sel_err;
  logic         game_over;
  logic [1:0]   winner;
  logic [7:0]   win_line;

  game_ctrl #(.COLOR_X(CX), .COLOR_O(CO)) dut (
    .pclk(pclk), .rst(rst),
    .start_req(start_req), .choice_valid(choice_valid),
    .choice_sym(choice_sym), .sel_valid(sel_valid),
    .sel_idx(sel_idx), .restart(restart),
    .start_en(start_en), .choice_en(choice_en),
    .square_en(square_en), .owner(owner),
    .square_color(square_color), .turn(turn),
    .sel_err(sel_err), .game_over(game_over),
    .winner(winner), .win_line(win_line)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_chk = 0;
  int n_pass = 0;
  int n_err_seen = 0;

  // Model: phase 0 title,1 choosing,2 playing,3 judging,4 finished
  int         m_ph;
  int         m_board [9];
  int         m_turn;
  int         m_moves;
  int         m_err;
  int         m_win;
  logic [7:0] m_line;
  int         ln [8][3] = '{
    '{0,1,2}, '{3,4,5}, '{6,7,8},
    '{0,3,6}, '{1,4,7}, '{2,5,8},
    '{0,4,8}, '{2,4,6}
  };

  task automatic chk(input string tag,
                     input logic [107:0] got,
                     input logic [107:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic m_clear();
    m_ph = 0;
    foreach (m_board[i]) m_board[i] = 0;
    m_turn = 0; m_moves = 0; m_err = 0;
    m_win = 0; m_line = '0;
  endtask

  task automatic m_step(input int s, cv, cs, sv, idx, rs);
    if (rs != 0) begin
      m_clear();
      return;
    end
    m_err = 0;
    if (m_ph == 0) begin
      if (s != 0) m_ph = 1;
    end else if (m_ph == 1) begin
      if (cv != 0) begin m_ph = 2; m_turn = cs; end
    end else if (m_ph == 2) begin
      if (sv != 0) begin
        if (idx <= 8 && m_board[idx] == 0) begin
          m_board[idx] = m_turn + 1;
          m_moves++;
          m_ph = 3;
        end else m_err = 1;
      end
    end else if (m_ph == 3) begin
      int w = 0;
      logic [7:0] lb = '0;
      for (int l = 0; l < 8; l++) begin
        int a = m_board[ln[l][0]];
        if (a != 0 && a == m_board[ln[l][1]]
            && a == m_board[ln[l][2]]) begin
          lb[l] = 1'b1; w = a;
        end
      end
      if (w != 0) begin
        m_ph = 4; m_win = w; m_line = lb;
      end else if (m_moves == 9) begin
        m_ph = 4; m_win = 3; m_line = '0;
      end else begin
        m_ph = 2; m_turn = 1 - m_turn;
      end
    end
  endtask

  task automatic check_all();
    logic [8:0]   e_sq, e_own;
    logic [107:0] e_col;
    e_sq = '0; e_own = '0; e_col = '0;
    for (int i = 0; i < 9; i++) begin
      if (m_board[i] != 0) e_sq[i] = 1'b1;
      if (m_board[i] == 2) e_own[i] = 1'b1;
      if (m_board[i] == 1) e_col[12*i +: 12] = CX;
      if (m_board[i] == 2) e_col[12*i +: 12] = CO;
    end
    chk("start_en", 108'(start_en), 108'(m_ph != 0));
    chk("choice_en", 108'(choice_en), 108'(m_ph == 1));
    chk("square_en", 108'(square_en), 108'(e_sq));
    chk("owner", 108'(owner), 108'(e_own));
    chk("square_color", square_color, e_col);
    chk("turn", 108'(turn), 108'(m_turn));
    chk("sel_err", 108'(sel_err), 108'(m_err));
    chk("game_over", 108'(game_over), 108'(m_ph == 4));
    chk("winner", 108'(winner), 108'(m_win));
    chk("win_line", 108'(win_line), 108'(m_line));
    if (sel_err) n_err_seen++;
  endtask

  task automatic cyc(input int s, cv, cs, sv, idx, rs);
    @(negedge pclk);
    start_req    = 1'(s);
    choice_valid = 1'(cv);
    choice_sym   = 1'(cs);
    sel_valid    = 1'(sv);
    sel_idx      = 4'(idx);
    restart      = 1'(rs);
    m_step(s, cv, cs, sv, idx, rs);
    @(posedge pclk);
    #1;
    check_all();
  endtask

  task automatic idle(); cyc(0, 0, 0, 0, 0, 0); endtask
  task automatic mv(input int idx);
    cyc(0, 0, 0, 1, idx, 0);
    idle();
  endtask
  task automatic new_game(input int sym);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, sym, 0, 0, 0);
  endtask

  initial begin
    int seq_win [5] = '{0, 3, 1, 4, 2};
    int seq_draw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    start_req = 0; choice_valid = 0; choice_sym = 0;
    sel_valid = 0; sel_idx = 0; restart = 0;
    rst = 1'b0;
    m_clear();
    #12;
    check_all();
    @(negedge pclk);
    rst = 1'b1;
    idle();

    // Mode sequence with O first
    cyc(1, 0, 0, 0, 0, 0);
    chk("start_en_after_req", 108'(start_en), 108'(1));
    cyc(0, 1, 1, 0, 0, 0);
    chk("turn_O_first", 108'(turn), 108'(1));
    chk("choice_en_low", 108'(choice_en), 108'(0));

    // X wins top row
    new_game(0);
    foreach (seq_win[k]) mv(seq_win[k]);
    chk("win_winner", 108'(winner), 108'(2'b01));
    chk("win_line_row0", 108'(win_line), 108'(8'h01));
    chk("win_over", 108'(game_over), 108'(1));
    chk("win_col0", 108'(square_color[11:0]), 108'(CX));
    chk("win_col3", 108'(square_color[47:36]), 108'(CO));
    cyc(0, 0, 0, 1, 7, 0);
    chk("over_ignores_sel", 108'(square_en[7]), 108'(0));

    // Async reset while finished
    @(negedge pclk);
    #2 rst = 1'b0;
    #1;
    m_clear();
    check_all();
    @(negedge pclk);
    rst = 1'b1;

    // Draw
    new_game(0);
    foreach (seq_draw[k]) mv(seq_draw[k]);
    chk("draw_winner", 108'(winner), 108'(2'b11));
    chk("draw_line", 108'(win_line), 108'(0));
    chk("draw_full", 108'(square_en), 108'(9'h1FF));

    // Rejected and dropped selections
    new_game(0);
    n_err_seen = 0;
    mv(4);
    cyc(0, 0, 0, 1, 4, 0);
    cyc(0, 0, 0, 1, 9, 0);
    idle();
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    idle();
    chk("err_pulses", 108'(n_err_seen), 108'(2));
    chk("check_drop", 108'(square_en), 108'(9'h011));

    // Restart with simultaneous select
    cyc(0, 0, 0, 1, 5, 1);
    chk("restart_clear", 108'(square_en), 108'(0));
    chk("restart_no_err", 108'(sel_err), 108'(0));

    // Randomized play
    for (int c = 0; c < 3000; c++) begin
      int s, cv, cs, sv, idx, rs;
      s   = ($urandom % 4 == 0) ? 1 : 0;
      cv  = ($urandom % 4 == 0) ? 1 : 0;
      cs  = $urandom % 2;
      sv  = $urandom % 2;
      idx = $urandom_range(0, 10);
      rs  = ($urandom % 60 == 0) ? 1 : 0;
      cyc(s, cv, cs, sv, idx, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Turn-sequencing controller for the tic-tac-toe board. It takes start, symbol-choice and square-select events from the mouse/keyboard decode logic and tracks the 3x3 board state. It drives the `start_en`/`choice_en` mode flags and per-square enables consumed by the `draw_square*` overlay chain. It detects win/draw and holds the result until restart.

## Interface

Parameters:
- `COLOR_X`, 12'hF00, RGB for squares owned by player X
- `COLOR_O`, 12'h00F, RGB for squares owned by player O

Ports:
- `pclk`  in  1  pixel clock; single clock domain
- `rst`  in  1  reset, asynchronous, active-low
- `start_req`  in  1  one-cycle pulse: leave title screen
- `choice_valid`  in  1  one-cycle pulse: first-player choice made
- `choice_sym`  in  1  0 = X moves first, 1 = O moves first
- `sel_valid`  in  1  one-cycle pulse: square clicked
- `sel_idx`  in  4  clicked square, 0..8 row-major (0 = top-left)
- `restart`  in  1  one-cycle pulse: clear board, return to IDLE
- `start_en`  out  1  high in all states except IDLE
- `choice_en`  out  1  high in CHOICE only
- `square_en`  out  9  bit i = square i occupied
- `owner`  out  9  bit i = 1 → O, 0 → X (valid where `square_en[i]`)
- `square_color`  out  108  12 bits per square, square i at [12i+11:12i]: COLOR_X/COLOR_O if occupied, 0 otherwise
- `turn`  out  1  player to move: 0 = X, 1 = O
- `sel_err`  out  1  one-cycle pulse: selection rejected
- `game_over`  out  1  high in OVER
- `winner`  out  2  00 none, 01 X, 10 O, 11 draw
- `win_line`  out  8  one-hot winning line: 0–2 rows, 3–5 cols, 6 diag 0-4-8, 7 diag 2-4-6

## Operation

States: IDLE, CHOICE, PLAY, CHECK, OVER.
- Reset (rst=0): state IDLE; every output 0; `square_color` all 0; move counter 0.
- IDLE: `start_req` → CHOICE.
- CHOICE: `choice_valid` → PLAY; `turn` ← `choice_sym`.
- PLAY: on `sel_valid`:
  - If `sel_idx` ≤ 8 and the square is free: set `square_en[sel_idx]`, set `owner[sel_idx]` ← `turn`, increment move counter (4 bit, 0..9), go to CHECK.
  - Otherwise (`sel_idx` > 8 or square occupied): pulse `sel_err`; board, `turn` and state unchanged.
- CHECK (exactly one cycle): evaluate the 8 lines on the registered board.
  - Any line with all three squares occupied and the same owner → OVER, `winner` = mover (01/10), `win_line` bit set. Only the lines through the last-placed square can win, and `win_line` may be multi-hot only in that case.
  - Else if move counter = 9 → OVER, `winner` = 11, `win_line` = 0.
  - Else → PLAY with `turn` toggled.
- OVER: hold board, `winner` and `win_line`; `sel_valid` ignored, no `sel_err`.
- `restart` in any state (synchronous): next edge → IDLE; board, counter, `turn`, `winner`, `win_line` cleared. `restart` has priority over all other inputs in the same cycle.
- Events not listed for a state are ignored: `start_req` outside IDLE, `choice_valid` outside CHOICE, `sel_valid` outside PLAY, and `sel_valid` during CHECK (it is dropped, not queued).
- `square_color` is registered and derived from next-state `square_en`/`owner`, so it updates in the same cycle as `square_en`.

## Timing

- All outputs are registered; no combinational input-to-output paths.
- `sel_valid` at edge N (accepted) → `square_en`/`owner`/`square_color` update at N+1, state = CHECK.
- Result at N+2: either `turn` toggled with state PLAY, or `game_over`/`winner`/`win_line` valid.
- Rejected `sel_valid` at edge N → `sel_err` high for cycle N+1 only.
- Mode flags: `start_req` at N → `start_en` at N+1; `choice_valid` at N → `choice_en` low at N+1.
- Asynchronous assertion of `rst` mid-game clears all outputs immediately. Deassertion is assumed synchronized upstream.
- Minimum spacing between accepted moves is 2 cycles.

## Test plan

- Reset/mode sequence: release rst, pulse `start_req`, then `choice_valid` with `choice_sym`=1 → `start_en`=1 one cycle after `start_req`; `choice_en` 1→0; `turn`=1; `square_en`=0.
- Win: X first; selects 0,3,1,4,2 → after the fifth move, `winner`=01, `win_line`=8'h01, `game_over`=1, `square_color[11:0]`=COLOR_X, `square_color[47:36]`=COLOR_O.
- Draw: selects 0,1,2,4,3,5,7,6,8 → `winner`=11, `win_line`=0, `square_en`=9'h1FF after the 9th move's CHECK.
- Rejects: select 4 twice, then `sel_idx`=9, then `sel_valid` in the cycle immediately after an accepted move → two `sel_err` pulses (occupied square, index 9); the CHECK-cycle `sel_valid` is dropped silently; `turn` toggled once.
- Restart mid-game, with `restart` and `sel_valid` in the same cycle → next cycle IDLE, all outputs 0, no `sel_err`.
- Async reset: drive rst=0 between clock edges while in OVER → all outputs 0 before the next `pclk` edge.
